// File: rtl/i2c_slave_fifo_pkg.sv
// i2c_slave_fifo_pkg
//   Shared constants and helpers for the I2C slave data buffer.
//   I2C_DATA_W   : byte width used on both the RX and TX paths.
//   fifo_ptr_w() : pointer width for a FIFO of a given depth. The pointer
//                  carries one extra wrap bit above the address bits.
package i2c_slave_fifo_pkg;

  localparam int I2C_DATA_W = 8;

  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/i2c_slave_fifo_if.sv
// i2c_slave_fifo_if
//   Bundles every non-clock/reset signal of i2c_slave_fifo.
//   slave  modport : the buffer itself.
//   master modport : slave_fsm + host/register side driving the buffer.
//   slave_fsm side : wr_en_fifo/wr_data/FIFO_FULL (RX push),
//                    rd_en_fifo/rd_data/FIFO_EMPTY (TX pop).
//   host side      : host_rx_rd/host_rx_data/host_rx_empty/host_rx_level,
//                    rx_almost_full, host_tx_wr/host_tx_data/host_tx_full/
//                    host_tx_level, fifo_flush, flag_clr, rx_overflow,
//                    tx_underflow.
//
// Handshake: a push request (wr_en_fifo / host_tx_wr) is accepted at a rising
// edge only when the matching full flag is low at that edge; a pop request
// (rd_en_fifo / host_rx_rd) is accepted only when the matching empty flag is
// low. The request itself is the valid, the inverted full/empty is the ready,
// and a request with ready low is dropped (not held) by the buffer.
interface i2c_slave_fifo_if #(
  parameter int DATA_W = i2c_slave_fifo_pkg::I2C_DATA_W,
  parameter int DEPTH  = 8
);
  localparam int LW = i2c_slave_fifo_pkg::fifo_ptr_w(DEPTH);

  logic              wr_en_fifo;
  logic [DATA_W-1:0] wr_data;
  logic              FIFO_FULL;
  logic              rd_en_fifo;
  logic [DATA_W-1:0] rd_data;
  logic              FIFO_EMPTY;
  logic              host_rx_rd;
  logic [DATA_W-1:0] host_rx_data;
  logic              host_rx_empty;
  logic [LW-1:0]     host_rx_level;
  logic              rx_almost_full;
  logic              host_tx_wr;
  logic [DATA_W-1:0] host_tx_data;
  logic              host_tx_full;
  logic [LW-1:0]     host_tx_level;
  logic              fifo_flush;
  logic              flag_clr;
  logic              rx_overflow;
  logic              tx_underflow;

  modport slave (
    input  wr_en_fifo, wr_data, rd_en_fifo, host_rx_rd, host_tx_wr,
           host_tx_data, fifo_flush, flag_clr,
    output FIFO_FULL, rd_data, FIFO_EMPTY, host_rx_data, host_rx_empty,
           host_rx_level, rx_almost_full, host_tx_full, host_tx_level,
           rx_overflow, tx_underflow
  );

  modport master (
    output wr_en_fifo, wr_data, rd_en_fifo, host_rx_rd, host_tx_wr,
           host_tx_data, fifo_flush, flag_clr,
    input  FIFO_FULL, rd_data, FIFO_EMPTY, host_rx_data, host_rx_empty,
           host_rx_level, rx_almost_full, host_tx_full, host_tx_level,
           rx_overflow, tx_underflow
  );

endinterface

// File: rtl/i2c_slave_fifo_sync_fifo.sv
// i2c_slave_fifo_sync_fifo
//   Single-clock first-word-fall-through FIFO used for both buffer paths.
//   clk, rst_n      : clock, synchronous active-low reset
//   flush           : return to empty at next edge, ignoring push/pop
//   push, push_data : write request and data
//   pop             : read request (head advances)
//   head_data       : current head entry, 0 while empty
//   full, empty     : occupancy flags derived from registered pointers only
//   level           : occupancy 0..DEPTH
//   overflow        : one-cycle pulse, push rejected because full
//   underflow       : one-cycle pulse, pop rejected because empty
module i2c_slave_fifo_sync_fifo
  import i2c_slave_fifo_pkg::*;
#(
  parameter int DATA_W = I2C_DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [fifo_ptr_w(DEPTH)-1:0] level,
  output logic              overflow,
  output logic              underflow
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_ok;
  logic              pop_ok;

  // Same address with differing wrap bits means the writer is a full lap ahead.
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  // Modulo-2*DEPTH difference yields 0..DEPTH directly.
  assign level = wr_ptr_q - rd_ptr_q;

  assign push_ok   = push && !full && !flush;
  assign pop_ok    = pop && !empty && !flush;
  assign overflow  = push && full && !flush;
  assign underflow = pop && empty && !flush;

  assign head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is intentionally not reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/i2c_slave_fifo.sv
// i2c_slave_fifo
//   Data buffer between slave_fsm and the host/register side.
//   RX path: bytes received by slave_fsm are queued for the host.
//   TX path: host-queued bytes are fed to slave_fsm during master reads.
//   Parameters: DATA_W (byte width), DEPTH (entries per path, power of 2,
//   >= 2), AF_THRESH (rx_almost_full when RX level >= AF_THRESH).
//   Ports:
//     clk_t : system clock, rising edge
//     rstn  : synchronous reset, active-low (wins over fifo_flush)
//     bus   : i2c_slave_fifo_if.slave, see the interface for signal roles
module i2c_slave_fifo
  import i2c_slave_fifo_pkg::*;
#(
  parameter int DATA_W    = I2C_DATA_W,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic clk_t,
  input  logic rstn,
  i2c_slave_fifo_if.slave bus
);

  localparam int LW = fifo_ptr_w(DEPTH);
  localparam logic [LW-1:0] AF_LEVEL = LW'(AF_THRESH);

  logic          rx_full, rx_empty, rx_ovf_pulse, rx_unused_unf;
  logic          tx_full, tx_empty, tx_unf_pulse, tx_unused_ovf;
  logic [LW-1:0] rx_level, tx_level;
  logic          rx_overflow_q, rx_overflow_d;
  logic          tx_underflow_q, tx_underflow_d;

  i2c_slave_fifo_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk_t),
    .rst_n     (rstn),
    .flush     (bus.fifo_flush),
    .push      (bus.wr_en_fifo),
    .push_data (bus.wr_data),
    .pop       (bus.host_rx_rd),
    .head_data (bus.host_rx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level),
    .overflow  (rx_ovf_pulse),
    .underflow (rx_unused_unf)
  );

  i2c_slave_fifo_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk_t),
    .rst_n     (rstn),
    .flush     (bus.fifo_flush),
    .push      (bus.host_tx_wr),
    .push_data (bus.host_tx_data),
    .pop       (bus.rd_en_fifo),
    .head_data (bus.rd_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level),
    .overflow  (tx_unused_ovf),
    .underflow (tx_unf_pulse)
  );

  // Host RX underflow and host TX overflow are deliberately not reported.
  logic unused_pulses;
  assign unused_pulses = &{1'b0, rx_unused_unf, tx_unused_ovf};

  assign bus.FIFO_FULL      = rx_full;
  assign bus.host_rx_empty  = rx_empty;
  assign bus.host_rx_level  = rx_level;
  assign bus.rx_almost_full = (rx_level >= AF_LEVEL);
  assign bus.FIFO_EMPTY     = tx_empty;
  assign bus.host_tx_full   = tx_full;
  assign bus.host_tx_level  = tx_level;
  assign bus.rx_overflow    = rx_overflow_q;
  assign bus.tx_underflow   = tx_underflow_q;

  // A new error event wins over a clear arriving in the same cycle.
  always_comb begin
    rx_overflow_d  = rx_overflow_q;
    tx_underflow_d = tx_underflow_q;
    if (bus.flag_clr) begin
      rx_overflow_d  = 1'b0;
      tx_underflow_d = 1'b0;
    end
    if (rx_ovf_pulse) rx_overflow_d  = 1'b1;
    if (tx_unf_pulse) tx_underflow_d = 1'b1;
  end

  always_ff @(posedge clk_t) begin
    if (!rstn) begin
      rx_overflow_q  <= 1'b0;
      tx_underflow_q <= 1'b0;
    end else begin
      rx_overflow_q  <= rx_overflow_d;
      tx_underflow_q <= tx_underflow_d;
    end
  end

endmodule
